// File: rtl/network_bf_out_pkg.sv
// Shared definitions for the bank <-> butterfly routing networks and the
// address generator: source-select encoding, bank count and the control beat.
package network_bf_out_pkg;

  localparam int NBANK  = 8;   // memory banks, also butterfly outputs (4 BFUs x 2)
  localparam int SEL_W  = 3;   // width of a per-bank source select
  localparam int DATA_W = 14;  // native coefficient width
  localparam int ADDR_W = 5;   // native bank address width (32 words per bank)

  // Source-select encoding: which butterfly output feeds a bank.
  localparam logic [SEL_W-1:0] SRC_X0 = 3'd0;
  localparam logic [SEL_W-1:0] SRC_Y0 = 3'd1;
  localparam logic [SEL_W-1:0] SRC_X1 = 3'd2;
  localparam logic [SEL_W-1:0] SRC_Y1 = 3'd3;
  localparam logic [SEL_W-1:0] SRC_X2 = 3'd4;
  localparam logic [SEL_W-1:0] SRC_Y2 = 3'd5;
  localparam logic [SEL_W-1:0] SRC_X3 = 3'd6;
  localparam logic [SEL_W-1:0] SRC_Y3 = 3'd7;

  typedef logic [SEL_W-1:0] sel_t;

  // One control beat for the native geometry: write strobe plus per-bank
  // source select and address.
  typedef struct packed {
    logic                          wen;
    logic [NBANK-1:0][SEL_W-1:0]   sel;
    logic [NBANK-1:0][ADDR_W-1:0]  addr;
  } ctrl_beat_t;

endpackage

// File: rtl/network_bf_out_ctrl_delay_line.sv
// Fixed-depth synchronous-reset shift register. Carries control beats from the
// cycle they are issued to the cycle the matching butterfly results arrive.
module network_bf_out_ctrl_delay_line #(
  parameter int width = 1,
  parameter int depth = 1
)(
  input  logic             clk,
  input  logic             rst,
  input  logic [width-1:0] din,
  output logic [width-1:0] dout
);

  logic [width-1:0] stage_reg [depth];

  // Shift one stage per cycle; reset empties the whole line so in-flight beats are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < depth; i++) stage_reg[i] <= '0;
    end else begin
      stage_reg[0] <= din;
      for (int i = 1; i < depth; i++) stage_reg[i] <= stage_reg[i-1];
    end
  end

  assign dout = stage_reg[depth-1];

endmodule

// File: rtl/network_bf_out.sv
// Write-back routing stage: steers the eight butterfly results into the eight
// banks using controls issued at read time and delayed to meet the data, and
// counts write beats to flag the end of each NTT stage.
module network_bf_out
  import network_bf_out_pkg::*;
#(
  parameter int data_width      = DATA_W,
  parameter int addr_width      = ADDR_W,
  parameter int pipe_depth      = 4,
  parameter int beats_per_stage = 32,
  localparam int cnt_w = (beats_per_stage > 1) ? $clog2(beats_per_stage) : 1
)(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [SEL_W-1:0]      sel_b_0,
  input  logic [SEL_W-1:0]      sel_b_1,
  input  logic [SEL_W-1:0]      sel_b_2,
  input  logic [SEL_W-1:0]      sel_b_3,
  input  logic [SEL_W-1:0]      sel_b_4,
  input  logic [SEL_W-1:0]      sel_b_5,
  input  logic [SEL_W-1:0]      sel_b_6,
  input  logic [SEL_W-1:0]      sel_b_7,
  input  logic [addr_width-1:0] wa_in_0,
  input  logic [addr_width-1:0] wa_in_1,
  input  logic [addr_width-1:0] wa_in_2,
  input  logic [addr_width-1:0] wa_in_3,
  input  logic [addr_width-1:0] wa_in_4,
  input  logic [addr_width-1:0] wa_in_5,
  input  logic [addr_width-1:0] wa_in_6,
  input  logic [addr_width-1:0] wa_in_7,
  input  logic                  wen_in,
  input  logic [data_width-1:0] x0,
  input  logic [data_width-1:0] y0,
  input  logic [data_width-1:0] x1,
  input  logic [data_width-1:0] y1,
  input  logic [data_width-1:0] x2,
  input  logic [data_width-1:0] y2,
  input  logic [data_width-1:0] x3,
  input  logic [data_width-1:0] y3,
  output logic [data_width-1:0] d0,
  output logic [data_width-1:0] d1,
  output logic [data_width-1:0] d2,
  output logic [data_width-1:0] d3,
  output logic [data_width-1:0] d4,
  output logic [data_width-1:0] d5,
  output logic [data_width-1:0] d6,
  output logic [data_width-1:0] d7,
  output logic [addr_width-1:0] wa0,
  output logic [addr_width-1:0] wa1,
  output logic [addr_width-1:0] wa2,
  output logic [addr_width-1:0] wa3,
  output logic [addr_width-1:0] wa4,
  output logic [addr_width-1:0] wa5,
  output logic [addr_width-1:0] wa6,
  output logic [addr_width-1:0] wa7,
  output logic                  wen,
  output logic                  stage_done,
  output logic [cnt_w-1:0]      beat_cnt
);

  // Control beat at this block's address width (the package struct is the
  // native-width equivalent).
  typedef struct packed {
    logic                             wen;
    logic [NBANK-1:0][SEL_W-1:0]      sel;
    logic [NBANK-1:0][addr_width-1:0] addr;
  } beat_t;

  localparam logic [cnt_w-1:0] last_beat = cnt_w'(beats_per_stage - 1);

  logic [SEL_W-1:0]         sel_in  [NBANK];
  logic [addr_width-1:0]    addr_in [NBANK];
  logic [data_width-1:0]    src     [NBANK];
  logic [data_width-1:0]    mux_out [NBANK];
  logic [data_width-1:0]    d_reg   [NBANK];
  logic [addr_width-1:0]    wa_reg  [NBANK];

  beat_t                    beat_in;
  beat_t                    beat_dly;
  logic [$bits(beat_t)-1:0] beat_dly_bits;

  logic                     wen_reg;
  logic                     stage_done_reg;
  logic [cnt_w-1:0]         cnt_reg;
  logic [cnt_w-1:0]         cnt_next;

  assign sel_in[0] = sel_b_0;  assign addr_in[0] = wa_in_0;
  assign sel_in[1] = sel_b_1;  assign addr_in[1] = wa_in_1;
  assign sel_in[2] = sel_b_2;  assign addr_in[2] = wa_in_2;
  assign sel_in[3] = sel_b_3;  assign addr_in[3] = wa_in_3;
  assign sel_in[4] = sel_b_4;  assign addr_in[4] = wa_in_4;
  assign sel_in[5] = sel_b_5;  assign addr_in[5] = wa_in_5;
  assign sel_in[6] = sel_b_6;  assign addr_in[6] = wa_in_6;
  assign sel_in[7] = sel_b_7;  assign addr_in[7] = wa_in_7;

  // Butterfly outputs laid out in source-select order.
  assign src[SRC_X0] = x0;
  assign src[SRC_Y0] = y0;
  assign src[SRC_X1] = x1;
  assign src[SRC_Y1] = y1;
  assign src[SRC_X2] = x2;
  assign src[SRC_Y2] = y2;
  assign src[SRC_X3] = x3;
  assign src[SRC_Y3] = y3;

  // Bundle the per-bank controls into one beat for the delay line.
  always_comb begin
    beat_in     = '0;
    beat_in.wen = wen_in;
    for (int i = 0; i < NBANK; i++) begin
      beat_in.sel[i]  = sel_in[i];
      beat_in.addr[i] = addr_in[i];
    end
  end

  network_bf_out_ctrl_delay_line #(
    .width ($bits(beat_t)),
    .depth (pipe_depth)
  ) u_ctrl_delay_line (
    .clk  (clk),
    .rst  (rst),
    .din  (beat_in),
    .dout (beat_dly_bits)
  );

  assign beat_dly = beat_t'(beat_dly_bits);

  for (genvar gi = 0; gi < NBANK; gi++) begin : g_bank
    // Gather: any bank may pick any source, duplicates simply copy.
    assign mux_out[gi] = src[beat_dly.sel[gi]];

    // Data and address register every cycle; only wen qualifies them.
    always_ff @(posedge clk) begin
      if (rst) begin
        d_reg[gi]  <= '0;
        wa_reg[gi] <= '0;
      end else begin
        d_reg[gi]  <= mux_out[gi];
        wa_reg[gi] <= beat_dly.addr[gi];
      end
    end
  end

  // Count of beats completed once the beat now on the outputs (if any) is written.
  always_comb begin
    cnt_next = cnt_reg;
    if (wen_reg) cnt_next = (cnt_reg == last_beat) ? '0 : cnt_reg + 1'b1;
  end

  // Write strobe and stage bookkeeping, registered alongside d/wa so that
  // beat_cnt shows beats already done and stage_done marks the last beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      wen_reg        <= 1'b0;
      cnt_reg        <= '0;
      stage_done_reg <= 1'b0;
    end else begin
      wen_reg        <= beat_dly.wen;
      cnt_reg        <= cnt_next;
      stage_done_reg <= beat_dly.wen && (cnt_next == last_beat);
    end
  end

  assign d0 = d_reg[0];  assign wa0 = wa_reg[0];
  assign d1 = d_reg[1];  assign wa1 = wa_reg[1];
  assign d2 = d_reg[2];  assign wa2 = wa_reg[2];
  assign d3 = d_reg[3];  assign wa3 = wa_reg[3];
  assign d4 = d_reg[4];  assign wa4 = wa_reg[4];
  assign d5 = d_reg[5];  assign wa5 = wa_reg[5];
  assign d6 = d_reg[6];  assign wa6 = wa_reg[6];
  assign d7 = d_reg[7];  assign wa7 = wa_reg[7];

  assign wen        = wen_reg;
  assign stage_done = stage_done_reg;
  assign beat_cnt   = cnt_reg;

endmodule

// File: tb/tb_network_bf_out.sv
// Scoreboard bench for network_bf_out: the driver pushes the expected bank
// writes for every issued beat; the monitor pops one entry per output wen.
module tb_network_bf_out;
  import network_bf_out_pkg::*;

  localparam int DW  = 14;
  localparam int AW  = 5;
  localparam int PD  = 4;
  localparam int BPS = 32;

  typedef logic [7:0][DW-1:0] dvec_t;
  typedef logic [7:0][2:0]    svec_t;
  typedef logic [7:0][AW-1:0] avec_t;

  typedef struct packed {
    dvec_t      d;
    avec_t      wa;
    logic       done;
    logic [4:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic wen_in = 1'b0;
  svec_t sel_v = '0;
  avec_t wa_v = '0;
  dvec_t src_v = '0;

  logic [DW-1:0] d0, d1, d2, d3, d4, d5, d6, d7;
  logic [AW-1:0] wa0, wa1, wa2, wa3, wa4, wa5, wa6, wa7;
  logic          wen, stage_done;
  logic [4:0]    beat_cnt;
  dvec_t         d_out;
  avec_t         wa_out;

  exp_t  exp_q[$];
  dvec_t data_hist[$];
  exp_t  mon_e;
  int    n_vec = 0;
  int    n_err = 0;
  int    model_cnt = 0;
  int    cyc = 0;
  bit    mon_en = 1'b0;
  bit    prev_rst = 1'b1;

  always #5 clk = ~clk;

  assign d_out  = {d7, d6, d5, d4, d3, d2, d1, d0};
  assign wa_out = {wa7, wa6, wa5, wa4, wa3, wa2, wa1, wa0};

  network_bf_out #(
    .data_width(DW), .addr_width(AW), .pipe_depth(PD), .beats_per_stage(BPS)
  ) dut (
    .clk(clk), .rst(rst),
    .sel_b_0(sel_v[0]), .sel_b_1(sel_v[1]), .sel_b_2(sel_v[2]), .sel_b_3(sel_v[3]),
    .sel_b_4(sel_v[4]), .sel_b_5(sel_v[5]), .sel_b_6(sel_v[6]), .sel_b_7(sel_v[7]),
    .wa_in_0(wa_v[0]), .wa_in_1(wa_v[1]), .wa_in_2(wa_v[2]), .wa_in_3(wa_v[3]),
    .wa_in_4(wa_v[4]), .wa_in_5(wa_v[5]), .wa_in_6(wa_v[6]), .wa_in_7(wa_v[7]),
    .wen_in(wen_in),
    .x0(src_v[0]), .y0(src_v[1]), .x1(src_v[2]), .y1(src_v[3]),
    .x2(src_v[4]), .y2(src_v[5]), .x3(src_v[6]), .y3(src_v[7]),
    .d0(d0), .d1(d1), .d2(d2), .d3(d3), .d4(d4), .d5(d5), .d6(d6), .d7(d7),
    .wa0(wa0), .wa1(wa1), .wa2(wa2), .wa3(wa3), .wa4(wa4), .wa5(wa5), .wa6(wa6), .wa7(wa7),
    .wen(wen), .stage_done(stage_done), .beat_cnt(beat_cnt)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // One clock: drive controls for a new beat, and the butterfly data that
  // pairs with the beat issued PD cycles earlier.
  task automatic step(input bit r, input bit we, input svec_t s, input avec_t a, input dvec_t dat);
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (prev_rst) begin
      exp_q.delete();
      model_cnt = 0;
    end
    prev_rst = r;
    rst    = r;
    wen_in = we;
    sel_v  = s;
    wa_v   = a;
    data_hist.push_back(dat);
    if (data_hist.size() > PD) src_v = data_hist.pop_front();
    else src_v = '1;
    if (we && !r) begin
      for (int i = 0; i < 8; i++) e.d[i] = dat[s[i]];
      e.wa   = a;
      e.cnt  = 5'(model_cnt);
      e.done = (model_cnt == BPS - 1);
      model_cnt = (model_cnt + 1) % BPS;
      exp_q.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    dvec_t junk;
    for (int c = 0; c < n; c++) begin
      for (int i = 0; i < 8; i++) junk[i] = DW'(14'h2000 + (cyc * 8 + i) % 4096);
      step(1'b0, 1'b0, '0, '0, junk);
    end
  endtask

  // Monitor: every output write beat must match the oldest expectation.
  always @(negedge clk) begin
    if (mon_en) begin
      if (wen !== 1'b1 && wen !== 1'b0) begin
        chk("wen_known", 128'(wen), 128'(0));
      end else if (wen) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_wen", 128'(wen), 128'(0));
        end else begin
          mon_e = exp_q.pop_front();
          chk("beat_d", 128'(d_out), 128'(mon_e.d));
          chk("beat_wa", 128'(wa_out), 128'(mon_e.wa));
          chk("beat_cnt", 128'(beat_cnt), 128'(mon_e.cnt));
          chk("beat_stage_done", 128'(stage_done), 128'(mon_e.done));
        end
      end else begin
        chk("idle_stage_done", 128'(stage_done), 128'(0));
      end
    end
  end

  initial begin
    svec_t s;
    avec_t a;
    dvec_t dat;
    bit    gap_pat [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

    // Reset with random live-looking beats on the inputs.
    for (int c = 0; c < 2; c++) begin
      for (int i = 0; i < 8; i++) begin
        s[i]   = 3'($urandom_range(7));
        a[i]   = 5'($urandom_range(31));
        dat[i] = 14'($urandom_range(16383));
      end
      step(1'b1, 1'b1, s, a, dat);
      mon_en = 1'b1;
    end
    @(negedge clk);
    chk("reset_d", 128'(d_out), 128'(0));
    chk("reset_wa", 128'(wa_out), 128'(0));
    chk("reset_wen", 128'(wen), 128'(0));
    chk("reset_stage_done", 128'(stage_done), 128'(0));
    chk("reset_beat_cnt", 128'(beat_cnt), 128'(0));
    for (int c = 0; c < PD + 1; c++) begin
      idle(1);
      @(negedge clk);
      chk("post_reset_wen", 128'(wen), 128'(0));
    end

    // Identity routing: bank i <- source i, data 10..17, address 3.
    for (int i = 0; i < 8; i++) begin
      s[i] = 3'(i); a[i] = 5'd3; dat[i] = 14'(10 + i);
    end
    step(1'b0, 1'b1, s, a, dat);

    // Broadcast y2 to every bank.
    for (int i = 0; i < 8; i++) begin
      s[i] = SRC_Y2; a[i] = 5'd7; dat[i] = 14'(16'h0111 * (i + 1));
    end
    dat[5] = 14'h1ABC;
    step(1'b0, 1'b1, s, a, dat);
    idle(PD + 2);

    // Fresh stage, then 32 back-to-back beats with address = beat index.
    step(1'b1, 1'b0, '0, '0, '0);
    step(1'b1, 1'b0, '0, '0, '0);
    idle(1);
    for (int b = 0; b < BPS; b++) begin
      for (int i = 0; i < 8; i++) begin
        s[i] = 3'((i + b) % 8); a[i] = 5'(b); dat[i] = 14'(16'h0100 + b * 8 + i);
      end
      step(1'b0, 1'b1, s, a, dat);
    end
    idle(PD + 2);
    @(negedge clk);
    chk("stream_cnt_wrap", 128'(beat_cnt), 128'(0));

    // Gapped beats 1,0,1,1,0.
    for (int j = 0; j < 5; j++) begin
      for (int i = 0; i < 8; i++) begin
        s[i] = 3'(7 - i); a[i] = 5'(20 + j); dat[i] = 14'(16'h2100 + j * 8 + i);
      end
      step(1'b0, gap_pat[j], s, a, dat);
    end
    idle(PD + 2);
    @(negedge clk);
    chk("gap_cnt", 128'(beat_cnt), 128'(3));

    // Seven more beats (10 in this stage), then reset with beats in flight.
    for (int b = 0; b < 7; b++) begin
      for (int i = 0; i < 8; i++) begin
        s[i] = 3'((i + 2 * b) % 8); a[i] = 5'(b + 3); dat[i] = 14'(16'h2200 + b * 8 + i);
      end
      step(1'b0, 1'b1, s, a, dat);
    end
    step(1'b1, 1'b1, s, a, dat);
    step(1'b1, 1'b1, s, a, dat);
    for (int b = 0; b < BPS; b++) begin
      for (int i = 0; i < 8; i++) begin
        s[i] = 3'((3 * i + b) % 8); a[i] = 5'(31 - b); dat[i] = 14'(16'h3000 + b * 8 + i);
      end
      step(1'b0, 1'b1, s, a, dat);
    end
    idle(PD + 3);
    @(negedge clk);
    chk("queue_drained", 128'(exp_q.size()), 128'(0));
    chk("final_cnt", 128'(beat_cnt), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
